// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   REG_AW / XLEN / NREGS : register-file geometry
//   wb_req_t              : one pending writeback (destination + data)
//   wb_src_e              : which source owns the write port this cycle
package reg_wb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   dat;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_A,
    SRC_B
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding long-latency writebacks until the write port
// is free. Head is read combinationally so the arbiter can commit it in the
// same cycle it is selected.
//   clk, rst      : clock, synchronous active-low reset (discards contents)
//   push/push_data: write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   head          : current head entry
//   count/empty/full : occupancy, all from registered state
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        mem_reg [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  logic           do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-port scheduler and long-latency scoreboard.
// Source A (single-cycle path) always wins the port with zero latency;
// source B (mul/div/load) is buffered and drains when A is idle.
//   clk, rst              : clock, synchronous active-low reset
//   i_a_wr_*              : source-A write request
//   i_b_vld/o_b_rdy/i_b_* : source-B handshake into the buffer
//   i_iss_vld/i_iss_addr  : long-latency issue, marks destination pending
//   o_wr_*                : register-file write port
//   o_pend                : per-register outstanding-B-write bitmap
//   o_hold                : asks the core to leave the A slot idle
//   o_err                 : sticky protocol-error flag
module reg_wb_sched
  import reg_wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_wr_en,
  input  logic [REG_AW-1:0] i_a_wr_addr,
  input  logic [XLEN-1:0]   i_a_wr_dat,
  input  logic              i_b_vld,
  output logic              o_b_rdy,
  input  logic [REG_AW-1:0] i_b_addr,
  input  logic [XLEN-1:0]   i_b_dat,
  input  logic              i_iss_vld,
  input  logic [REG_AW-1:0] i_iss_addr,
  output logic              o_wr_en,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [XLEN-1:0]   o_wr_dat,
  output logic [NREGS-1:0]  o_pend,
  output logic              o_hold,
  output logic              o_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t          b_req, head;
  logic [CW-1:0]    count;
  logic             empty, full;
  logic             push, pop;
  wb_src_e          src;
  logic             sel_en;

  logic [NREGS-1:0] pend_reg, pend_next;
  logic [3:0]       age_reg, age_next;
  logic             hold_reg;
  logic             err_reg, err_next;
  logic             iss_err, a_pend_err, b_push_err, hold_err;

  // ---------------- source-B buffer ----------------
  // Ready comes from registered occupancy only: a full buffer refuses a
  // push even in a cycle where it also pops.
  assign o_b_rdy = rst && (count < CW'(DEPTH));
  assign push    = i_b_vld && o_b_rdy;
  assign b_req   = '{addr: i_b_addr, dat: i_b_dat};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (b_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // ---------------- arbiter ----------------
  always_comb begin
    src = SRC_NONE;
    if (i_a_wr_en)   src = SRC_A;
    else if (!empty) src = SRC_B;
  end

  assign pop = rst && (src == SRC_B);

  always_comb begin
    sel_en    = 1'b0;
    o_wr_addr = '0;
    o_wr_dat  = '0;
    case (src)
      SRC_A: begin
        sel_en    = 1'b1;
        o_wr_addr = i_a_wr_addr;
        o_wr_dat  = i_a_wr_dat;
      end
      SRC_B: begin
        sel_en    = 1'b1;
        o_wr_addr = head.addr;
        o_wr_dat  = head.dat;
      end
      default: ;
    endcase
  end

  // Writes to x0 are consumed but never reach the register file.
  assign o_wr_en = rst && sel_en && (o_wr_addr != '0);

  // ---------------- scoreboard ----------------
  // Bit 0 is hardwired clear; for the rest a same-cycle issue beats the clear.
  assign pend_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
    assign pend_next[gi] = (i_iss_vld && (i_iss_addr == REG_AW'(gi))) ||
                           (pend_reg[gi] && !(pop && (head.addr == REG_AW'(gi))));
  end

  // ---------------- starvation ----------------
  always_comb begin
    age_next = age_reg;
    if (empty || pop)
      age_next = '0;
    else if (age_reg != 4'(STARVE_MAX))
      age_next = age_reg + 4'd1;
  end

  // ---------------- protocol errors ----------------
  // An issue to a register whose pending write commits this same cycle is legal.
  assign iss_err    = i_iss_vld && pend_reg[i_iss_addr] &&
                      !(pop && (head.addr == i_iss_addr));
  assign a_pend_err = i_a_wr_en && (i_a_wr_addr != '0) && pend_reg[i_a_wr_addr];
  assign b_push_err = push && !pend_reg[i_b_addr];
  assign hold_err   = i_a_wr_en && hold_reg;
  assign err_next   = err_reg || iss_err || a_pend_err || b_push_err || hold_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_reg <= '0;
      age_reg  <= '0;
      hold_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      age_reg  <= age_next;
      hold_reg <= (age_next == 4'(STARVE_MAX));
      err_reg  <= err_next;
    end
  end

  assign o_pend = pend_reg;
  assign o_hold = rst && hold_reg;
  assign o_err  = err_reg;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed testbench for reg_wb_sched (DEPTH=2, STARVE_MAX=4).
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_a_wr_en;
  logic [4:0]  i_a_wr_addr;
  logic [31:0] i_a_wr_dat;
  logic        i_b_vld;
  logic        o_b_rdy;
  logic [4:0]  i_b_addr;
  logic [31:0] i_b_dat;
  logic        i_iss_vld;
  logic [4:0]  i_iss_addr;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_dat;
  logic [31:0] o_pend;
  logic        o_hold;
  logic        o_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reg_wb_sched #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_a_wr_en   (i_a_wr_en),
    .i_a_wr_addr (i_a_wr_addr),
    .i_a_wr_dat  (i_a_wr_dat),
    .i_b_vld     (i_b_vld),
    .o_b_rdy     (o_b_rdy),
    .i_b_addr    (i_b_addr),
    .i_b_dat     (i_b_dat),
    .i_iss_vld   (i_iss_vld),
    .i_iss_addr  (i_iss_addr),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_dat    (o_wr_dat),
    .o_pend      (o_pend),
    .o_hold      (o_hold),
    .o_err       (o_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_a_wr_en = 0; i_a_wr_addr = 0; i_a_wr_dat = 0;
    i_b_vld = 0; i_b_addr = 0; i_b_dat = 0;
    i_iss_vld = 0; i_iss_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    i_a_wr_en = 1; i_a_wr_addr = 5; i_a_wr_dat = 32'h1;
    step(); step();
    tests_run++;
    if (o_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", o_wr_en); end
    tests_run++;
    if (o_pend !== 32'h0) begin tests_failed++; $display("FAIL reset_pend: got %h want 0", o_pend); end
    tests_run++;
    if (o_b_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_b_rdy: got %b want 0", o_b_rdy); end
    tests_run++;
    if (o_err !== 1'b0 || o_hold !== 1'b0) begin tests_failed++; $display("FAIL reset_err_hold: got err=%b hold=%b want 0/0", o_err, o_hold); end
    rst = 1;
    i_a_wr_en = 0;
    #1;
    tests_run++;
    if (o_b_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_release_rdy: got %b want 1", o_b_rdy); end
    $display("[TB] reset: rst low 2 cycles with A requesting, released");
  endtask

  task automatic test_a_only();
    i_a_wr_en = 1; i_a_wr_addr = 5; i_a_wr_dat = 32'h1234;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd5 || o_wr_dat !== 32'h1234) begin
      tests_failed++;
      $display("FAIL a_write_x5: got en=%b addr=%0d dat=%h want 1/5/00001234", o_wr_en, o_wr_addr, o_wr_dat);
    end
    $display("[TB] A write x5=0x1234");
    i_a_wr_addr = 0; i_a_wr_dat = 32'hFFFF;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b0) begin tests_failed++; $display("FAIL a_write_x0: got en=%b want 0", o_wr_en); end
    $display("[TB] A write x0 suppressed");
    step();
    i_a_wr_en = 0;
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("FAIL a_only_err: got %b want 0", o_err); end
  endtask

  task automatic test_b_path();
    i_iss_vld = 1; i_iss_addr = 7;
    step();
    i_iss_vld = 0;
    tests_run++;
    if (o_pend !== 32'h0000_0080) begin tests_failed++; $display("FAIL b_issue_pend: got %h want 00000080", o_pend); end
    i_b_vld = 1; i_b_addr = 7; i_b_dat = 32'hDEAD;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b0) begin tests_failed++; $display("FAIL b_no_bypass: got en=%b want 0", o_wr_en); end
    step();
    i_b_vld = 0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd7 || o_wr_dat !== 32'hDEAD) begin
      tests_failed++;
      $display("FAIL b_commit_x7: got en=%b addr=%0d dat=%h want 1/7/0000dead", o_wr_en, o_wr_addr, o_wr_dat);
    end
    tests_run++;
    if (o_pend !== 32'h0000_0080) begin tests_failed++; $display("FAIL b_pend_during_commit: got %h want 00000080", o_pend); end
    $display("[TB] B push x7=0xDEAD committed");
    step();
    tests_run++;
    if (o_pend !== 32'h0 || o_wr_en !== 1'b0) begin tests_failed++; $display("FAIL b_after_commit: got pend=%h en=%b want 0/0", o_pend, o_wr_en); end
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("FAIL b_path_err: got %b want 0", o_err); end
  endtask

  task automatic test_full();
    i_iss_vld = 1; i_iss_addr = 8;
    step();
    i_iss_addr = 9;
    step();
    i_iss_vld = 0;
    i_a_wr_en = 1; i_a_wr_addr = 10; i_a_wr_dat = 32'hA0;
    i_b_vld = 1; i_b_addr = 8; i_b_dat = 32'h88;
    step();
    i_b_addr = 9; i_b_dat = 32'h99;
    step();
    tests_run++;
    if (o_b_rdy !== 1'b0) begin tests_failed++; $display("FAIL full_rdy: got %b want 0", o_b_rdy); end
    $display("[TB] two B pushes under busy A, buffer full");
    i_b_addr = 9; i_b_dat = 32'hBAD;
    step(); step();
    tests_run++;
    if (o_b_rdy !== 1'b0 || o_hold !== 1'b0) begin tests_failed++; $display("FAIL full_held: got rdy=%b hold=%b want 0/0", o_b_rdy, o_hold); end
    i_b_vld = 0;
    i_a_wr_en = 0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd8 || o_wr_dat !== 32'h88) begin
      tests_failed++;
      $display("FAIL full_drain0: got en=%b addr=%0d dat=%h want 1/8/00000088", o_wr_en, o_wr_addr, o_wr_dat);
    end
    step();
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd9 || o_wr_dat !== 32'h99) begin
      tests_failed++;
      $display("FAIL full_drain1: got en=%b addr=%0d dat=%h want 1/9/00000099", o_wr_en, o_wr_addr, o_wr_dat);
    end
    tests_run++;
    if (o_b_rdy !== 1'b1) begin tests_failed++; $display("FAIL full_rdy_after_pop: got %b want 1", o_b_rdy); end
    step();
    tests_run++;
    if (o_wr_en !== 1'b0 || o_pend !== 32'h0) begin tests_failed++; $display("FAIL full_third_rejected: got en=%b pend=%h want 0/0", o_wr_en, o_pend); end
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("FAIL full_err: got %b want 0", o_err); end
    $display("[TB] buffer drained x8, x9; held third entry not accepted");
  endtask

  task automatic test_starvation();
    i_iss_vld = 1; i_iss_addr = 12;
    step();
    i_iss_vld = 0;
    i_a_wr_en = 1; i_a_wr_addr = 13; i_a_wr_dat = 32'h13;
    i_b_vld = 1; i_b_addr = 12; i_b_dat = 32'hC;
    step();
    i_b_vld = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (o_hold !== 1'b0) begin tests_failed++; $display("FAIL starve_early_hold%0d: got %b want 0", k, o_hold); end
    end
    step();
    tests_run++;
    if (o_hold !== 1'b1) begin tests_failed++; $display("FAIL starve_hold: got %b want 1", o_hold); end
    i_a_wr_en = 0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd12 || o_wr_dat !== 32'hC) begin
      tests_failed++;
      $display("FAIL starve_commit: got en=%b addr=%0d dat=%h want 1/12/0000000c", o_wr_en, o_wr_addr, o_wr_dat);
    end
    step();
    tests_run++;
    if (o_hold !== 1'b0 || o_pend !== 32'h0 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_release: got hold=%b pend=%h err=%b want 0/0/0", o_hold, o_pend, o_err);
    end
    $display("[TB] starvation hold raised after 4 cycles and released");
  endtask

  task automatic test_errors();
    // double issue
    i_iss_vld = 1; i_iss_addr = 3;
    step();
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("FAIL err_first_issue: got %b want 0", o_err); end
    step();
    i_iss_vld = 0;
    step(); step();
    tests_run++;
    if (o_err !== 1'b1) begin tests_failed++; $display("FAIL err_double_issue: got %b want 1", o_err); end
    do_reset();
    tests_run++;
    if (o_err !== 1'b0 || o_pend !== 32'h0) begin tests_failed++; $display("FAIL err_reset1: got err=%b pend=%h want 0/0", o_err, o_pend); end
    $display("[TB] double issue x3 flagged, cleared by reset");

    // push to an unpending register, then reset mid-operation
    i_b_vld = 1; i_b_addr = 4; i_b_dat = 32'h44;
    step();
    i_b_vld = 0;
    tests_run++;
    if (o_err !== 1'b1) begin tests_failed++; $display("FAIL err_unpending_push: got %b want 1", o_err); end
    rst = 0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b0) begin tests_failed++; $display("FAIL err_reset_forces_wr: got %b want 0", o_wr_en); end
    step();
    rst = 1;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b0 || o_err !== 1'b0) begin tests_failed++; $display("FAIL err_reset_discard: got en=%b err=%b want 0/0", o_wr_en, o_err); end
    $display("[TB] B push to unpending x4 flagged, reset discarded entry");

    // A write while hold is raised
    i_iss_vld = 1; i_iss_addr = 20;
    step();
    i_iss_vld = 0;
    i_a_wr_en = 1; i_a_wr_addr = 21; i_a_wr_dat = 32'h21;
    i_b_vld = 1; i_b_addr = 20; i_b_dat = 32'h20;
    step();
    i_b_vld = 0;
    step(); step(); step(); step();
    tests_run++;
    if (o_hold !== 1'b1 || o_err !== 1'b0) begin tests_failed++; $display("FAIL err_hold_setup: got hold=%b err=%b want 1/0", o_hold, o_err); end
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd21) begin tests_failed++; $display("FAIL err_a_wins_hold: got en=%b addr=%0d want 1/21", o_wr_en, o_wr_addr); end
    step();
    tests_run++;
    if (o_err !== 1'b1 || o_hold !== 1'b1) begin tests_failed++; $display("FAIL err_a_during_hold: got err=%b hold=%b want 1/1", o_err, o_hold); end
    i_a_wr_en = 0;
    #1;
    tests_run++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 5'd20 || o_wr_dat !== 32'h20) begin
      tests_failed++;
      $display("FAIL err_hold_commit: got en=%b addr=%0d dat=%h want 1/20/00000020", o_wr_en, o_wr_addr, o_wr_dat);
    end
    step();
    tests_run++;
    if (o_err !== 1'b1 || o_hold !== 1'b0) begin tests_failed++; $display("FAIL err_sticky: got err=%b hold=%b want 1/0", o_err, o_hold); end
    do_reset();
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("FAIL err_reset3: got %b want 0", o_err); end
    $display("[TB] A write during hold flagged, sticky until reset");
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_a_only();
    test_b_path();
    test_full();
    test_starvation();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
